shift_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 32-bit `Barrel_Shifter`. It accepts shift requests from two independent requesters (A, B) over valid/ready handshakes and grants the single shifter to at most one requester per cycle, round-robin. It registers each result into a per-port response slot drained by its own valid/ready handshake. It sits between the ALU issue logic and the shifter, so neither requester instantiates its own shifter.

---
 rtl/shift_arbiter_pkg.sv | 9 +
 rtl/barrel_shifter.sv | 19 +
 rtl/shift_arbiter.sv | 108 ++++++++++
 tb/tb_shift_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared constants for the two-port shifter arbiter
package shift_arbiter_pkg;
   localparam logic SH_LEFT  = 1'b0;
   localparam logic SH_RIGHT = 1'b1;
   localparam logic PORT_A   = 1'b0;
   localparam logic PORT_B   = 1'b1;
   localparam int   DATA_W_DFLT = 32;
   localparam int   AMT_W_DFLT  = 5;
endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - 32-bit barrel shifter, arithmetic right or logical left
module Barrel_Shifter
   import shift_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int AMT_W  = AMT_W_DFLT
)(
   input  logic              SH_DIR,
   input  logic [AMT_W-1:0]  SH_AMT,
   input  logic [DATA_W-1:0] D_IN,
   output logic [DATA_W-1:0] D_OUT
);
   logic [DATA_W-1:0] w_right;
   logic [DATA_W-1:0] w_left;

   assign w_right = DATA_W'($signed(D_IN) >>> SH_AMT);
   assign w_left  = D_IN << SH_AMT;
   assign D_OUT   = (SH_DIR == SH_RIGHT) ? w_right : w_left;
endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one barrel shifter between ports A and B
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int AMT_W  = AMT_W_DFLT
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              A_VALID,
   output logic              A_READY,
   input  logic              A_DIR,
   input  logic [AMT_W-1:0]  A_AMT,
   input  logic [DATA_W-1:0] A_DATA,
   output logic              A_RVALID,
   input  logic              A_RREADY,
   output logic [DATA_W-1:0] A_RDATA,
   input  logic              B_VALID,
   output logic              B_READY,
   input  logic              B_DIR,
   input  logic [AMT_W-1:0]  B_AMT,
   input  logic [DATA_W-1:0] B_DATA,
   output logic              B_RVALID,
   input  logic              B_RREADY,
   output logic [DATA_W-1:0] B_RDATA,
   output logic              LAST_GNT
);
   logic              r_last_gnt;
   logic              w_elig_a;
   logic              w_elig_b;
   logic              w_gnt_a;
   logic              w_gnt_b;
   logic              w_sh_dir;
   logic [AMT_W-1:0]  w_sh_amt;
   logic [DATA_W-1:0] w_sh_in;
   logic [DATA_W-1:0] w_sh_out;
   logic [1:0]        w_gnt;
   logic [1:0]        w_rready;

   // A port may be granted only if its result slot is free or being drained now.
   assign w_elig_a = A_VALID && (!A_RVALID || A_RREADY);
   assign w_elig_b = B_VALID && (!B_RVALID || B_RREADY);

   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (!Rst) begin
         if (w_elig_a && (!w_elig_b || r_last_gnt == PORT_B)) begin
            w_gnt_a = 1'b1;
         end else if (w_elig_b) begin
            w_gnt_b = 1'b1;
         end
      end
   end

   assign A_READY  = w_gnt_a;
   assign B_READY  = w_gnt_b;
   assign w_sh_dir = w_gnt_b ? B_DIR  : A_DIR;
   assign w_sh_amt = w_gnt_b ? B_AMT  : A_AMT;
   assign w_sh_in  = w_gnt_b ? B_DATA : A_DATA;

   Barrel_Shifter #(
      .DATA_W (DATA_W),
      .AMT_W  (AMT_W)
   ) u_shifter (
      .SH_DIR (w_sh_dir),
      .SH_AMT (w_sh_amt),
      .D_IN   (w_sh_in),
      .D_OUT  (w_sh_out)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_last_gnt <= PORT_B;
      end else if (w_gnt_a) begin
         r_last_gnt <= PORT_A;
      end else if (w_gnt_b) begin
         r_last_gnt <= PORT_B;
      end
   end

   assign w_gnt    = {w_gnt_b, w_gnt_a};
   assign w_rready = {B_RREADY, A_RREADY};

   for (genvar g = 0; g < 2; g++) begin : g_slot
      logic              r_rvalid;
      logic [DATA_W-1:0] r_rdata;

      // A grant wins over a drain so a same-cycle drain+grant keeps the slot full.
      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
         end else if (w_gnt[g]) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_sh_out;
         end else if (r_rvalid && w_rready[g]) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign A_RVALID = g_slot[0].r_rvalid;
   assign A_RDATA  = g_slot[0].r_rdata;
   assign B_RVALID = g_slot[1].r_rvalid;
   assign B_RDATA  = g_slot[1].r_rdata;
   assign LAST_GNT = r_last_gnt;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter against a behavioural model
module tb_shift_arbiter;
   logic        Clk = 1'b0;
   logic        Rst;
   logic        A_VALID, A_READY, A_DIR, A_RVALID, A_RREADY;
   logic [4:0]  A_AMT;
   logic [31:0] A_DATA, A_RDATA;
   logic        B_VALID, B_READY, B_DIR, B_RVALID, B_RREADY;
   logic [4:0]  B_AMT;
   logic [31:0] B_DATA, B_RDATA;
   logic        LAST_GNT;

   int n_tests = 0;
   int n_fail  = 0;

   bit          m_rv [2];
   logic [31:0] m_rd [2];
   bit          m_last;
   bit          m_ga, m_gb;
   logic [31:0] held;

   shift_arbiter dut (
      .Clk(Clk), .Rst(Rst),
      .A_VALID(A_VALID), .A_READY(A_READY), .A_DIR(A_DIR), .A_AMT(A_AMT), .A_DATA(A_DATA),
      .A_RVALID(A_RVALID), .A_RREADY(A_RREADY), .A_RDATA(A_RDATA),
      .B_VALID(B_VALID), .B_READY(B_READY), .B_DIR(B_DIR), .B_AMT(B_AMT), .B_DATA(B_DATA),
      .B_RVALID(B_RVALID), .B_RREADY(B_RREADY), .B_RDATA(B_RDATA),
      .LAST_GNT(LAST_GNT)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Shift computed by multiplication/division on a 64-bit sign-extended value.
   function automatic logic [31:0] ref_shift(input bit dir, input int amt, input logic [31:0] d);
      longint unsigned x;
      longint unsigned p;
      p = 64'd1 << amt;
      if (!dir) begin
         x = {32'h0, d} * p;
      end else begin
         x = (d[31] ? {32'hFFFF_FFFF, d} : {32'h0, d}) / p;
      end
      return x[31:0];
   endfunction

   task automatic model_reset();
      m_rv[0] = 0; m_rv[1] = 0;
      m_rd[0] = '0; m_rd[1] = '0;
      m_last = 1;
   endtask

   task automatic check_outputs();
      check("A_RVALID", A_RVALID, m_rv[0]);
      check("B_RVALID", B_RVALID, m_rv[1]);
      check("A_RDATA", A_RDATA, m_rd[0]);
      check("B_RDATA", B_RDATA, m_rd[1]);
      check("LAST_GNT", LAST_GNT, m_last);
   endtask

   task automatic cycle();
      bit ea, eb;
      @(negedge Clk);
      ea = A_VALID && (!m_rv[0] || A_RREADY);
      eb = B_VALID && (!m_rv[1] || B_RREADY);
      m_ga = ea && (!eb || m_last);
      m_gb = eb && !m_ga;
      check("A_READY", A_READY, m_ga);
      check("B_READY", B_READY, m_gb);
      if (m_ga) begin
         m_rv[0] = 1; m_rd[0] = ref_shift(A_DIR, A_AMT, A_DATA);
      end else if (m_rv[0] && A_RREADY) m_rv[0] = 0;
      if (m_gb) begin
         m_rv[1] = 1; m_rd[1] = ref_shift(B_DIR, B_AMT, B_DATA);
      end else if (m_rv[1] && B_RREADY) m_rv[1] = 0;
      if (m_ga) m_last = 0;
      else if (m_gb) m_last = 1;
      @(posedge Clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1;
      A_VALID = 0; B_VALID = 0; A_RREADY = 1; B_RREADY = 1;
      model_reset();
      @(posedge Clk);
      #1;
      check("rst_A_READY", A_READY, 0);
      check_outputs();
      Rst = 0;
   endtask

   task automatic set_a(input bit dir, input int amt, input logic [31:0] d);
      A_VALID = 1; A_DIR = dir; A_AMT = 5'(amt); A_DATA = d;
   endtask

   task automatic set_b(input bit dir, input int amt, input logic [31:0] d);
      B_VALID = 1; B_DIR = dir; B_AMT = 5'(amt); B_DATA = d;
   endtask

   initial begin
      Rst = 1;
      A_VALID = 0; A_DIR = 0; A_AMT = 0; A_DATA = 0; A_RREADY = 1;
      B_VALID = 0; B_DIR = 0; B_AMT = 0; B_DATA = 0; B_RREADY = 1;
      do_reset();

      // Arithmetic right shift on port A.
      set_a(1, 4, 32'h8000_0000);
      cycle();
      check("plan_a_ready", {31'b0, m_ga}, 1);
      check("plan_a_rdata", A_RDATA, 32'hF800_0000);
      check("plan_a_rvalid", A_RVALID, 1);
      A_VALID = 0;

      // Back-to-back left shifts on port B.
      set_b(0, 31, 32'h0000_0001);
      cycle();
      check("plan_b_rdata0", B_RDATA, 32'h8000_0000);
      set_b(0, 0, 32'h4000_0000);
      cycle();
      check("plan_b_rdata1", B_RDATA, 32'h4000_0000);
      B_VALID = 0;
      cycle();

      // Contention straight after reset: A, B, A, B.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (!A_VALID || m_ga) set_a(1'($urandom), $urandom_range(31), $urandom);
         if (!B_VALID || m_gb) set_b(1'($urandom), $urandom_range(31), $urandom);
         cycle();
         check("alt_last", LAST_GNT, i % 2);
      end
      A_VALID = 0; B_VALID = 0;
      cycle();

      // Backpressure on A while B proceeds.
      set_a(0, 3, 32'h0000_0011);
      cycle();
      A_RREADY = 0;
      set_a(1, 1, 32'hF000_0000);
      set_b(0, 8, 32'h0000_00AB);
      held = A_RDATA;
      cycle();
      check("bp_a_ready", {31'b0, m_ga}, 0);
      check("bp_b_ready", {31'b0, m_gb}, 1);
      check("bp_a_hold", A_RDATA, held);
      B_VALID = 0;
      cycle();
      check("bp_a_hold2", A_RDATA, held);
      A_RREADY = 1;
      cycle();
      check("bp_regrant", {31'b0, m_ga}, 1);
      check("bp_rvalid", A_RVALID, 1);
      check("bp_rdata", A_RDATA, 32'hF800_0000);

      // Right-shift boundaries.
      set_a(1, 30, 32'h4000_0000);
      cycle();
      check("rs30", A_RDATA, 32'h0000_0001);
      set_a(1, 31, 32'h4000_0000);
      cycle();
      check("rs31", A_RDATA, 32'h0000_0000);

      // Asynchronous reset with a held result and B requesting.
      A_RREADY = 0;
      set_b(0, 1, 32'h1234_5678);
      cycle();
      check("ar_pre_rvalid", A_RVALID, 1);
      #2;
      Rst = 1;
      #1;
      model_reset();
      check("ar_a_ready", A_READY, 0);
      check("ar_b_ready", B_READY, 0);
      check_outputs();
      A_VALID = 0; B_VALID = 0; A_RREADY = 1; B_RREADY = 1;
      @(posedge Clk);
      #1;
      Rst = 0;
      for (int i = 0; i < 3; i++) cycle();

      // Randomized traffic with operands held while waiting for a grant.
      for (int i = 0; i < 400; i++) begin
         if (!(A_VALID && !m_ga)) begin
            A_VALID = 1'($urandom_range(99) < 60);
            A_DIR = 1'($urandom); A_AMT = 5'($urandom); A_DATA = $urandom;
         end
         if (!(B_VALID && !m_gb)) begin
            B_VALID = 1'($urandom_range(99) < 60);
            B_DIR = 1'($urandom); B_AMT = 5'($urandom); B_DATA = $urandom;
         end
         A_RREADY = 1'($urandom_range(99) < 70);
         B_RREADY = 1'($urandom_range(99) < 70);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
